mul_hilo_seq: RTL and testbench

//  Multi-cycle MULT/MULTU engine and HI/LO register pair for the 54-instruction CPU.

---
 rtl/mul_hilo_seq.sv | 109 ++++++++++
 tb/tb_mul_hilo_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mul_hilo_seq.sv
// Multi-cycle MULT/MULTU shift-add engine with the HI/LO register pair.
// Also serves MTHI/MTLO writes; busy stalls the pipeline during a multiply.
module mul_hilo_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             neg;

  logic             sgn;
  logic [WIDTH-1:0] amag;
  logic [WIDTH-1:0] bmag;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] res;

  // Magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    sgn  = op[0];
    amag = (sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
    bmag = (sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  // acc is the upper product half; mplier drains into the lower half.
  always_comb begin
    sum  = {1'b0, acc};
    if (mplier[0])
      sum = {1'b0, acc} + {1'b0, mcand};
    prod = {acc, mplier};
    res  = neg ? (~prod + 1'b1) : prod;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (!op[1]) begin
              mcand  <= amag;
              mplier <= bmag;
              acc    <= '0;
              cnt    <= CW'(WIDTH - 1);
              neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
              busy   <= 1'b1;
              state  <= RUN;
            end else if (op[0]) begin
              lo <= a;
            end else begin
              hi <= a;
            end
          end
        end
        RUN: begin
          acc    <= sum[WIDTH:1];
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          cnt    <= cnt - 1'b1;
          if (cnt == '0)
            state <= FIX;
        end
        FIX: begin
          {hi, lo} <= res;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_hilo_seq.sv
// Scoreboard bench for mul_hilo_seq: driver pushes reference products,
// monitor pops and compares on every done pulse.
module tb_mul_hilo_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  mul_hilo_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] exp;
    int          cyc;
  } exp_t;

  exp_t         q[$];
  int           errs = 0;
  int           checks = 0;
  int           cyc = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_mul(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
    longint sx, sy;
    longint unsigned ux, uy;
    if (o[0]) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = longint'(x);
    uy = longint'(y);
    return 64'(ux * uy);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: every done must match the oldest pending product and latency.
  always @(negedge clk) begin
    if (reset && done) begin
      exp_t e;
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_done actual=1 required=0 hi=%h lo=%h",
                 hi, lo);
      end else begin
        e = q.pop_front();
        chk("product", {hi, lo}, e.exp);
        chk("latency", 64'(cyc - e.cyc), 64'(W + 1));
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    int n = 0;
    logic [63:0] e;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errs++;
      $display("FAIL wait_idle busy=%0b required=0", busy);
    end
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 2'($urandom);
    if (!o[1]) begin
      e = ref_mul(o, x, y);
      q.push_back('{exp: e, cyc: cyc});
      {m_hi, m_lo} = e;
      chk("busy_after_accept", 64'(busy), 64'd1);
    end else begin
      if (o[0]) m_lo = x;
      else m_hi = x;
      chk("mt_hilo", {hi, lo}, {m_hi, m_lo});
      chk("mt_busy", 64'(busy), 64'd0);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #1;
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    issue(2'b00, 32'd7, 32'd6);
    issue(2'b01, 32'hFFFFFFFD, 32'd5);
    issue(2'b01, 32'h80000000, 32'h80000000);
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(2'b01, 32'd0, 32'hFFFFFFF0);
    issue(2'b01, 32'h7FFFFFFF, 32'h80000000);
    issue(2'b10, 32'h12345678, 32'd0);
    issue(2'b11, 32'h9ABCDEF0, 32'd0);
    @(negedge clk);
    chk("mt_no_done", 64'(done), 64'd0);

    // A start while busy must be dropped entirely.
    issue(2'b00, 32'd1000, 32'd1000);
    repeat (9) @(negedge clk);
    start = 1'b1;
    op = 2'b00;
    a = 32'd2;
    b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("busy_during_ignored", 64'(busy), 64'd1);
    drain();

    // Abort mid-run with reset.
    issue(2'b01, 32'hDEADBEEF, 32'h01234567);
    repeat (14) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    q.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    issue(2'b00, 32'd4, 32'd4);
    drain();

    for (int i = 0; i < 24; i++)
      issue(2'($urandom), $urandom, $urandom);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
